fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that sits directly upstream of the synchronous instruction memory. It owns the program counter and drives the word-index `pc` into the memory. It pairs each instruction returned one cycle later with the PC that fetched it, and presents both to decode through an IF/ID pipeline register. It supports hazard stalls and branch/jump redirects without dropping or duplicating instructions.

## Interface
Parameters:
- `PC_W`, 32, width of `pc_out` / PC fields.
- `MEM_DEPTH`, 128, instruction memory depth in words; PC counts modulo this.
- `RESET_PC`, 0, word index fetched first after reset.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID contents this edge.
- `redirect`  in  1  taken branch/jump: refetch from `redirect_pc`, flush the wrong-path instruction.
- `redirect_pc`  in  PC_W  target word index; taken modulo MEM_DEPTH.
- `pc_out`  out  PC_W  word index to instruction memory, sampled by memory on posedge.
- `inst_in`  in  32  memory output: the instruction at the `pc_out` of the previous edge.
- `id_inst`  out  32  IF/ID instruction; NOP (32'h0) when `id_valid`=0.
- `id_pc`  out  PC_W  PC of `id_inst`.
- `id_pc_plus1`  out  PC_W  `id_pc`+1 mod MEM_DEPTH, for branch target math.
- `id_valid`  out  1  IF/ID holds a real instruction.

## Operation
- State registers:
  - `pc`: next index to fetch.
  - `req_pc` / `req_valid`: index and validity of the request currently reflected on `inst_in`.
  - IF/ID registers.
- `pc_out` mux, combinational, in priority order:
  - `redirect` → `redirect_pc` mod MEM_DEPTH.
  - else `stall` → `req_pc`, so memory re-reads the held instruction.
  - else → `pc`.
- Edge with `rst`:
  - `pc`←RESET_PC, `req_pc`←0, `req_valid`←0.
  - `id_inst`←0, `id_pc`←0, `id_valid`←0.
  - `pc_out` = RESET_PC while `rst` is high.
- Edge with `redirect`; overrides `stall`:
  - `req_pc`←target, `req_valid`←1, `pc`←target+1.
  - IF/ID ← bubble: `id_valid`←0, `id_inst`←0, `id_pc` unchanged.
- Edge with `stall` and no `redirect`: every register holds.
- Normal edge:
  - `req_pc`←`pc`, `req_valid`←1, `pc`←`pc`+1.
  - `id_inst`←`inst_in`, `id_pc`←`req_pc`, `id_valid`←`req_valid`.
- Arithmetic: all PC increments wrap MEM_DEPTH-1 → 0. Bits of `pc_out` above clog2(MEM_DEPTH) are 0.
- `rst` dominates `redirect` and `stall` at every edge, including mid-stall and mid-redirect.

## Timing
- Fetch-to-decode latency: 2 edges. The index presented at edge n appears on `inst_in` after edge n, and is registered into IF/ID at edge n+1.
- First valid `id_*` appears after the 2nd edge following `rst` deassertion.
- Redirect penalty: 1 bubble. The target instruction is valid in IF/ID 2 edges after the redirect edge.
- Stall of k cycles holds IF/ID for exactly k edges. The instruction sequence after release is contiguous.
- Throughput: 1 instruction per cycle when neither `stall` nor `redirect` is asserted.

## Structure
- Shared package `cpu_pkg`:
  - `PC_W`, `MEM_DEPTH`, `INST_W`=32.
  - `NOP_INST`=32'h0.
  - PC width derived as clog2(MEM_DEPTH).
- One natural sub-module: `pc_reg`, holding the PC register plus its increment/wrap and redirect/stall next-state logic.
- The IF/ID register stays in `fetch_unit`.

## Test plan
- **Reset and free-run.** Setup: mem[0..3]=A,B,C,D, `rst` high 2 cycles then low. Required: `id_valid`=0 for 1 edge. Then (`id_pc`,`id_inst`)=(0,A),(1,B),(2,C),(3,D) on consecutive edges, with `id_pc_plus1`=1,2,3,4.
- **Stall.** Stimulus: `stall` held 3 cycles while IF/ID holds (1,B). Required: IF/ID stays (1,B) and `pc_out`=2 throughout. After release: (2,C),(3,D) with no skip or duplicate.
- **Redirect.** Stimulus: `redirect`=1, `redirect_pc`=0x10 while IF/ID holds (2,C). Required: next edge `id_valid`=0 and `id_inst`=0. The following edge gives (0x10, mem[0x10]), then (0x11, mem[0x11]).
- **Redirect with stall.** Stimulus: `redirect` and `stall` asserted on the same edge, `redirect_pc`=5. Required: redirect wins and `pc_out`=5 that cycle. IF/ID shows a bubble, then (5, mem[5]).
- **Wrap.** Stimulus: redirect to 126 and run free. Required: IF/ID shows `id_pc`=126, then 127, then 0, then 1. `id_pc_plus1`=0 when `id_pc`=127.
- **Reset mid-operation.** Stimulus: `rst` asserted during an active `stall` with IF/ID valid. Required: at the next edge `id_valid`=0, `id_inst`=0, `id_pc`=0, and `pc_out`=RESET_PC. The fetch order then restarts from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared constants and helpers for the CPU front end (fetch stage)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   // Default program-counter field width seen by the rest of the pipeline
   localparam int PC_W      = 32;
   // Instruction memory depth in words; program counters count modulo this
   localparam int MEM_DEPTH = 128;
   // Instruction word width
   localparam int INST_W    = 32;
   // Instruction used as a pipeline bubble
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
   // Number of bits actually needed to index the instruction memory
   localparam int PC_IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   // Word-index increment that wraps from depth-1 back to 0. Written against
   // the depth rather than a bit width so non-power-of-two memories also wrap.
   function automatic int unsigned wrap_inc(input int unsigned idx,
                                            input int unsigned depth);
      return ((idx + 32'd1) >= depth) ? 32'd0 : (idx + 32'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_reg
//  Brief    : Program counter of the fetch stage. Holds the next index to
//             fetch plus the index/validity of the request currently being
//             answered by the memory, and selects the index presented to the
//             instruction memory (reset, redirect, stall replay or sequential).
//  Revision : 1.0 - initial release
// ============================================================================
module pc_reg #(
   parameter int PC_W      = 32,
   parameter int MEM_DEPTH = 128,
   parameter int RESET_PC  = 0,
   parameter int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect,
   input  logic [PC_W-1:0]  redirect_pc,
   output logic [IDX_W-1:0] fetch_idx,
   output logic [IDX_W-1:0] req_idx,
   output logic             req_valid
);
   import cpu_pkg::*;

   localparam logic [PC_W-1:0]  c_depth     = PC_W'(MEM_DEPTH);
   localparam logic [IDX_W-1:0] c_reset_idx = IDX_W'(RESET_PC % MEM_DEPTH);

   logic [PC_W-1:0]  w_target_mod;
   logic [IDX_W-1:0] w_target;
   logic [IDX_W-1:0] w_target_inc;
   logic [IDX_W-1:0] w_pc_inc;
   logic [IDX_W-1:0] r_pc;
   logic [IDX_W-1:0] r_req_idx;
   logic             r_req_valid;

   // Redirect targets arrive as full-width PCs; fold them into the memory range
   assign w_target_mod = redirect_pc % c_depth;
   assign w_target     = w_target_mod[IDX_W-1:0];

   // After the modulo the high bits are always zero and are intentionally dropped
   generate
      if (PC_W > IDX_W) begin : g_target_hi
         logic w_unused_target_hi;
         assign w_unused_target_hi = |w_target_mod[PC_W-1:IDX_W];
      end
   endgenerate

   // Sequential successors, wrapping at the end of memory
   assign w_pc_inc     = IDX_W'(wrap_inc(32'(r_pc), MEM_DEPTH));
   assign w_target_inc = IDX_W'(wrap_inc(32'(w_target), MEM_DEPTH));

   // Memory address mux: reset, then redirect, then stall replay, else sequential
   always_comb begin
      fetch_idx = r_pc;
      if (rst) begin
         fetch_idx = c_reset_idx;
      end else if (redirect) begin
         fetch_idx = w_target;
      end else if (stall) begin
         // Re-read the request in flight so inst_in stays stable while held
         fetch_idx = r_req_idx;
      end
   end

   // PC and in-flight request tracking; redirect overrides stall
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= c_reset_idx;
         r_req_idx   <= '0;
         r_req_valid <= 1'b0;
      end else if (redirect) begin
         r_req_idx   <= w_target;
         r_req_valid <= 1'b1;
         r_pc        <= w_target_inc;
      end else if (!stall) begin
         r_req_idx   <= r_pc;
         r_req_valid <= 1'b1;
         r_pc        <= w_pc_inc;
      end
   end

   assign req_idx   = r_req_idx;
   assign req_valid = r_req_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction-fetch stage in front of a synchronous instruction
//             memory. Drives the memory word index, pairs each returned
//             instruction with the PC that fetched it and presents both to
//             decode through the IF/ID register, honouring stalls and
//             branch/jump redirects.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int PC_W      = cpu_pkg::PC_W,
   parameter int MEM_DEPTH = cpu_pkg::MEM_DEPTH,
   parameter int RESET_PC  = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       redirect,
   input  logic [PC_W-1:0]            redirect_pc,
   output logic [PC_W-1:0]            pc_out,
   input  logic [cpu_pkg::INST_W-1:0] inst_in,
   output logic [cpu_pkg::INST_W-1:0] id_inst,
   output logic [PC_W-1:0]            id_pc,
   output logic [PC_W-1:0]            id_pc_plus1,
   output logic                       id_valid
);
   import cpu_pkg::*;

   localparam int c_idx_w = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   logic [c_idx_w-1:0] w_fetch_idx;
   logic [c_idx_w-1:0] w_req_idx;
   logic               w_req_valid;
   logic [c_idx_w-1:0] w_id_pc_inc;

   logic [INST_W-1:0]  r_id_inst;
   logic [c_idx_w-1:0] r_id_pc;
   logic               r_id_valid;

   pc_reg #(
      .PC_W      (PC_W),
      .MEM_DEPTH (MEM_DEPTH),
      .RESET_PC  (RESET_PC),
      .IDX_W     (c_idx_w)
   ) u_pc_reg (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fetch_idx   (w_fetch_idx),
      .req_idx     (w_req_idx),
      .req_valid   (w_req_valid)
   );

   // Index fields are zero-extended so bits above the memory range read 0
   assign pc_out = PC_W'(w_fetch_idx);

   // IF/ID register: bubble on redirect, hold on stall, else capture memory data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_id_inst  <= NOP_INST;
         r_id_pc    <= '0;
         r_id_valid <= 1'b0;
      end else if (redirect) begin
         // Wrong-path instruction is squashed; id_pc is left as it was
         r_id_inst  <= NOP_INST;
         r_id_valid <= 1'b0;
      end else if (!stall) begin
         // Memory data is meaningless until the first request has been issued
         r_id_inst  <= w_req_valid ? inst_in : NOP_INST;
         r_id_pc    <= w_req_idx;
         r_id_valid <= w_req_valid;
      end
   end

   assign w_id_pc_inc = c_idx_w'(wrap_inc(32'(r_id_pc), MEM_DEPTH));

   assign id_inst     = r_id_inst;
   assign id_pc       = PC_W'(r_id_pc);
   assign id_pc_plus1 = PC_W'(w_id_pc_inc);
   assign id_valid    = r_id_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Self-checking bench for fetch_unit: directed vector table for the
//             documented scenarios, then random stall/redirect/reset traffic
//             checked against an instruction-stream reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam int DEPTH = 128;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] pc_out;
   logic [31:0] inst_in;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus1;
   logic        id_valid;

   logic [31:0] mem [DEPTH];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        r;
      logic        s;
      logic        d;
      logic [31:0] rpc;
      logic [31:0] exp_pcout;
      logic        exp_valid;
      logic        chk_pc;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl [24];

   // reference model state: the instruction stream as decode should see it
   int          m_next;
   bit          m_bub;
   logic        m_v;
   int          m_pc;
   logic [31:0] m_inst;
   logic        rr, rs, rd;
   logic [31:0] rp;
   int          tgt;
   int          exp_pco;

   fetch_unit #(
      .PC_W      (32),
      .MEM_DEPTH (DEPTH),
      .RESET_PC  (0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc_out      (pc_out),
      .inst_in     (inst_in),
      .id_inst     (id_inst),
      .id_pc       (id_pc),
      .id_pc_plus1 (id_pc_plus1),
      .id_valid    (id_valid)
   );

   always #5 clk = ~clk;

   // synchronous instruction memory: data for the index sampled at this edge
   always @(posedge clk) inst_in <= mem[pc_out[6:0]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic r, input logic s, input logic d, input logic [31:0] p);
      @(negedge clk);
      rst = r; stall = s; redirect = d; redirect_pc = p;
      #1;
   endtask

   task automatic row(input int i, input logic r, input logic s, input logic d,
                      input logic [31:0] p, input logic [31:0] pco, input logic v,
                      input logic cp, input logic [31:0] pc);
      tbl[i] = '{r, s, d, p, pco, v, cp, pc};
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom_range(1, 16'hFFFF), 16'(i)};

      //       idx rst stl red rpc      pc_out  valid chkpc id_pc
      row( 0, 1, 0, 0, 32'd0,   32'd0,   0, 1, 32'd0);
      row( 1, 1, 0, 0, 32'd0,   32'd0,   0, 1, 32'd0);
      row( 2, 0, 0, 0, 32'd0,   32'd0,   0, 0, 32'd0);   // startup bubble
      row( 3, 0, 0, 0, 32'd0,   32'd1,   1, 1, 32'd0);   // A
      row( 4, 0, 0, 0, 32'd0,   32'd2,   1, 1, 32'd1);   // B
      row( 5, 0, 1, 0, 32'd0,   32'd2,   1, 1, 32'd1);   // stall x3 holds B
      row( 6, 0, 1, 0, 32'd0,   32'd2,   1, 1, 32'd1);
      row( 7, 0, 1, 0, 32'd0,   32'd2,   1, 1, 32'd1);
      row( 8, 0, 0, 0, 32'd0,   32'd3,   1, 1, 32'd2);   // C
      row( 9, 0, 0, 0, 32'd0,   32'd4,   1, 1, 32'd3);   // D
      row(10, 0, 0, 1, 32'h10,  32'h10,  0, 0, 32'd0);   // redirect bubble
      row(11, 0, 0, 0, 32'd0,   32'h11,  1, 1, 32'h10);
      row(12, 0, 0, 0, 32'd0,   32'h12,  1, 1, 32'h11);
      row(13, 0, 1, 1, 32'd5,   32'd5,   0, 0, 32'd0);   // redirect beats stall
      row(14, 0, 0, 0, 32'd0,   32'd6,   1, 1, 32'd5);
      row(15, 0, 0, 1, 32'd254, 32'd126, 0, 0, 32'd0);   // target taken mod depth
      row(16, 0, 0, 0, 32'd0,   32'd127, 1, 1, 32'd126);
      row(17, 0, 0, 0, 32'd0,   32'd0,   1, 1, 32'd127); // wrap
      row(18, 0, 0, 0, 32'd0,   32'd1,   1, 1, 32'd0);
      row(19, 0, 0, 0, 32'd0,   32'd2,   1, 1, 32'd1);
      row(20, 0, 1, 0, 32'd0,   32'd2,   1, 1, 32'd1);
      row(21, 1, 1, 1, 32'd9,   32'd0,   0, 1, 32'd0);   // reset dominates mid-stall
      row(22, 0, 0, 0, 32'd0,   32'd0,   0, 0, 32'd0);
      row(23, 0, 0, 0, 32'd0,   32'd1,   1, 1, 32'd0);

      for (int i = 0; i < 24; i++) begin
         apply(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].rpc);
         chk($sformatf("vec%0d pc_out", i), pc_out, tbl[i].exp_pcout);
         @(posedge clk); #1;
         chk($sformatf("vec%0d id_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].exp_valid});
         chk($sformatf("vec%0d id_inst", i), id_inst,
             tbl[i].exp_valid ? mem[tbl[i].exp_pc[6:0]] : 32'h0);
         if (tbl[i].chk_pc)
            chk($sformatf("vec%0d id_pc", i), id_pc, tbl[i].exp_pc);
         if (tbl[i].exp_valid)
            chk($sformatf("vec%0d id_pc_plus1", i), id_pc_plus1, (tbl[i].exp_pc + 32'd1) % 32'd128);
      end

      // random traffic against the stream model
      m_next = 0; m_bub = 1'b1; m_v = 1'b0; m_pc = 0; m_inst = 32'h0;
      for (int n = 0; n < 3000; n++) begin
         rr = (n == 0) || ($urandom_range(0, 99) == 0);
         rs = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 7) == 0);
         rp = $urandom;
         tgt = int'(rp % 32'd128);
         if (rr)          exp_pco = 0;
         else if (rd)     exp_pco = tgt;
         else if (rs)     exp_pco = m_bub ? 0 : m_next;
         else             exp_pco = m_bub ? m_next : (m_next + 1) % DEPTH;
         apply(rr, rs, rd, rp);
         chk($sformatf("rnd%0d pc_out", n), pc_out, 32'(exp_pco));
         @(posedge clk); #1;
         if (rr) begin
            m_next = 0; m_bub = 1'b1; m_v = 1'b0; m_pc = 0; m_inst = 32'h0;
         end else if (rd) begin
            m_next = tgt; m_bub = 1'b0; m_v = 1'b0; m_inst = 32'h0;
         end else if (!rs) begin
            if (m_bub) begin
               m_bub = 1'b0; m_v = 1'b0; m_inst = 32'h0;
            end else begin
               m_v = 1'b1; m_pc = m_next; m_inst = mem[m_next];
               m_next = (m_next + 1) % DEPTH;
            end
         end
         chk($sformatf("rnd%0d id_valid", n), {31'd0, id_valid}, {31'd0, m_v});
         chk($sformatf("rnd%0d id_inst", n), id_inst, m_inst);
         if (rr)
            chk($sformatf("rnd%0d id_pc reset", n), id_pc, 32'd0);
         if (m_v) begin
            chk($sformatf("rnd%0d id_pc", n), id_pc, 32'(m_pc));
            chk($sformatf("rnd%0d id_pc_plus1", n), id_pc_plus1, 32'((m_pc + 1) % DEPTH));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
